p405s_trc_deserializer: RTL and testbench
=========================================

P405S_TRC_DESERIALIZER -- requirements
Module: p405s_trc_deserializer

Interface
REQ-001 SHALL have parameter: GAP_MAX, default 15, max consecutive idle cycles (serValid=0) allowed inside a packet before abort.
REQ-002 SHALL have port: CB  input  1  clock; all state samples on rising edge.
REQ-003 SHALL have port: resetN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: serDataIn  input  [0:2]  trace beat, true polarity.
REQ-005 SHALL have port: serValid  input  1  beat qualifier.
REQ-006 SHALL have port: serStart  input  1  marks beat 0 of a packet; meaningful only with serValid=1.
REQ-007 SHALL have port: tsEnable  input  1  sampled on the start beat; 1 = 13-beat packet with timestamp, 0 = 10-beat packet.
REQ-008 SHALL have port: pktReady  input  1  consumer accepts the held packet.
REQ-009 SHALL have port: pktValid  output  1  held packet available.
REQ-010 SHALL have port: pktData  output  [0:29]  reassembled trace data.
REQ-011 SHALL have port: pktTimeStamp  output  [0:8]  reassembled timestamp; zero when pktHasTs=0.
REQ-012 SHALL have port: pktHasTs  output  1  held packet carried a timestamp.
REQ-013 SHALL have port: frameErr  output  1  one-cycle pulse on framing fault.
REQ-014 SHALL have port: overrun  output  1  one-cycle pulse when a completed packet is dropped.
REQ-015 SHALL have port: busy  output  1  assembly in progress (state not IDLE).

Function
REQ-016 SHALL implement states IDLE, DATA, TS, plus a 4-bit beat index and a gap counter sized to hold GAP_MAX.
REQ-017 Beat mapping SHALL be: beat k (0..9) -> pktData[3k:3k+2]; beats 10,11,12 -> pktTimeStamp[0:2],[3:5],[6:8].
REQ-018 IDLE: serValid&serStart SHALL capture beat 0, latch tsEnable, and go to DATA with index 1.
REQ-019 IDLE: serValid without serStart SHALL be discarded and pulse frameErr.
REQ-020 DATA/TS: serValid&!serStart SHALL capture the beat at the current index and increment the index; DATA goes to TS after beat 9 when tsEnable was latched as 1.
REQ-021 Packet completes on accepting beat 9 (no timestamp) or beat 12 (timestamp); the state SHALL then return to IDLE.
REQ-022 DATA/TS: serValid&serStart SHALL pulse frameErr, discard the partial packet, and treat the beat as a new beat 0 (restart; tsEnable re-latched).
REQ-023 DATA/TS: the gap counter SHALL clear on each accepted beat and increment on each serValid=0 cycle; reaching GAP_MAX+1 SHALL pulse frameErr, discard the partial packet, and go to IDLE.
REQ-024 A completed packet SHALL be loaded into the output holding register and pktValid SHALL assert the cycle after the final beat is sampled (latency 1).
REQ-025 The handshake SHALL retire the held packet when pktValid&pktReady; pktData, pktTimeStamp, and pktHasTs SHALL stay stable while pktValid=1 and pktReady=0.
REQ-026 Completion while pktValid=1 and pktReady=0 SHALL drop the new packet, keep the held one, and pulse overrun.
REQ-027 Completion in the same cycle as pktValid&pktReady SHALL load the new packet with pktValid held at 1 (no bubble, no overrun).
REQ-028 Assembly SHALL continue regardless of pktValid; back-pressure never stalls serial input.
REQ-029 serStart with serValid=0 SHALL be ignored in all states.

Reset
REQ-030 resetN=0 SHALL asynchronously force IDLE, index 0, gap counter 0, pktValid=0, pktData=0, pktTimeStamp=0, pktHasTs=0, frameErr=0, overrun=0, busy=0.
REQ-031 Deassertion mid-packet SHALL leave no partial packet; the next packet SHALL begin only with a new start beat.
REQ-032 After resetN deasserts, the first capture SHALL occur on the first rising CB edge that sees resetN=1.

Verification
REQ-033 Timestamp packet: 13 back-to-back beats encoding pktData=30'h2AAAAAAA and ts=9'h1A5, with tsEnable=1 and pktReady=1 -> pktValid for 1 cycle, 1 cycle after beat 12, with exact values and pktHasTs=1.
REQ-034 Short packet with gaps: 10 beats with tsEnable=0 and 3-cycle gaps (GAP_MAX=15) -> correct pktData, pktTimeStamp=0, pktHasTs=0, no frameErr.
REQ-035 Restart: serStart on beat 5 of a packet -> frameErr pulse, and only the second packet is delivered.
REQ-036 Timeout: 16 idle cycles after beat 4 -> frameErr on the 16th idle cycle, busy=0, no pktValid.
REQ-037 Back-pressure: pktReady=0 while two packets complete -> first packet held stable, overrun pulses at the second completion; pktReady=1 on the cycle of a third completion -> third packet loaded without a bubble.
REQ-038 Reset mid-packet: resetN low at beat 7 -> all outputs at 0 immediately; a following full packet is delivered correctly.

Source files
------------

// File: rtl/p405s_trc_deserializer_if.sv
// Serial trace input and reassembled packet output of the trace deserializer.
// master = trace source / packet consumer side, slave = deserializer side.
interface p405s_trc_deserializer_if;
    logic [0:2]  serDataIn;
    logic        serValid;
    logic        serStart;
    logic        tsEnable;
    logic        pktReady;
    logic        pktValid;
    logic [0:29] pktData;
    logic [0:8]  pktTimeStamp;
    logic        pktHasTs;
    logic        frameErr;
    logic        overrun;
    logic        busy;

    modport master (
        output serDataIn, serValid, serStart, tsEnable, pktReady,
        input  pktValid, pktData, pktTimeStamp, pktHasTs, frameErr, overrun, busy
    );

    modport slave (
        input  serDataIn, serValid, serStart, tsEnable, pktReady,
        output pktValid, pktData, pktTimeStamp, pktHasTs, frameErr, overrun, busy
    );
endinterface

// File: rtl/p405s_trc_deserializer.sv
// Reassembles 3-bit trace beats into 10-beat (data) or 13-beat (data+timestamp)
// packets and presents them through a one-deep valid/ready holding register.
module p405s_trc_deserializer #(
    parameter int unsigned GAP_MAX = 15
) (
    input  logic                     CB,
    input  logic                     resetN,
    p405s_trc_deserializer_if.slave  trc
);
    localparam int unsigned GAP_W  = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned BEAT_W = 3;
    localparam int unsigned DATA_W = 30;
    localparam int unsigned TS_W   = 9;

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(9);
    localparam logic [IDX_W-1:0] LAST_TS   = IDX_W'(12);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TS   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [GAP_W-1:0]   gap, gap_nxt;
    logic               ts_en, ts_en_nxt;
    logic [0:DATA_W-1]  data_sr;
    logic [0:TS_W-1]    ts_sr;

    logic               shift_data;
    logic               shift_ts;
    logic               done;
    logic               frame_err_nxt;

    logic [0:DATA_W-1]  data_shift_c;
    logic [0:TS_W-1]    ts_shift_c;
    logic [0:DATA_W-1]  hold_data_c;
    logic [0:TS_W-1]    hold_ts_c;
    logic               hold_has_ts_c;

    // Beats shift in from the right, so after the last beat beat 0 sits at index 0.
    assign data_shift_c = {data_sr[BEAT_W:DATA_W-1], trc.serDataIn};
    assign ts_shift_c   = {ts_sr[BEAT_W:TS_W-1], trc.serDataIn};

    // A packet can only complete from DATA (no timestamp) or from TS.
    assign hold_has_ts_c = (state == TS);
    assign hold_data_c   = hold_has_ts_c ? data_sr : data_shift_c;
    assign hold_ts_c     = hold_has_ts_c ? ts_shift_c : '0;

    // Next-state and beat bookkeeping.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        gap_nxt       = gap;
        ts_en_nxt     = ts_en;
        shift_data    = 1'b0;
        shift_ts      = 1'b0;
        done          = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (trc.serValid) begin
                    if (trc.serStart) begin
                        state_nxt  = DATA;
                        idx_nxt    = IDX_W'(1);
                        gap_nxt    = '0;
                        ts_en_nxt  = trc.tsEnable;
                        shift_data = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end

            DATA, TS: begin
                if (trc.serValid && trc.serStart) begin
                    // Restart: the partial packet is dropped and this is beat 0.
                    frame_err_nxt = 1'b1;
                    state_nxt     = DATA;
                    idx_nxt       = IDX_W'(1);
                    gap_nxt       = '0;
                    ts_en_nxt     = trc.tsEnable;
                    shift_data    = 1'b1;
                end else if (trc.serValid) begin
                    gap_nxt = '0;
                    if (state == DATA) begin
                        shift_data = 1'b1;
                        if (idx == LAST_DATA) begin
                            if (ts_en) begin
                                state_nxt = TS;
                                idx_nxt   = idx + IDX_W'(1);
                            end else begin
                                done      = 1'b1;
                                state_nxt = IDLE;
                                idx_nxt   = '0;
                            end
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        shift_ts = 1'b1;
                        if (idx == LAST_TS) begin
                            done      = 1'b1;
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end else if (gap == GAP_LIMIT) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = IDLE;
                    idx_nxt       = '0;
                    gap_nxt       = '0;
                end else begin
                    gap_nxt = gap + GAP_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                gap_nxt   = '0;
            end
        endcase
    end

    // Assembly state and beat shift registers.
    always_ff @(posedge CB or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            idx     <= '0;
            gap     <= '0;
            ts_en   <= 1'b0;
            data_sr <= '0;
            ts_sr   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            gap   <= gap_nxt;
            ts_en <= ts_en_nxt;
            if (shift_data) begin
                data_sr <= data_shift_c;
            end
            if (shift_ts) begin
                ts_sr <= ts_shift_c;
            end
        end
    end

    // Output holding register, status pulses and busy flag.
    always_ff @(posedge CB or negedge resetN) begin
        if (!resetN) begin
            trc.pktValid     <= 1'b0;
            trc.pktData      <= '0;
            trc.pktTimeStamp <= '0;
            trc.pktHasTs     <= 1'b0;
            trc.frameErr     <= 1'b0;
            trc.overrun      <= 1'b0;
            trc.busy         <= 1'b0;
        end else begin
            trc.frameErr <= frame_err_nxt;
            trc.overrun  <= 1'b0;
            trc.busy     <= (state_nxt != IDLE);
            if (done) begin
                // A same-cycle retire frees the slot, so the new packet follows without a bubble.
                if (trc.pktValid && !trc.pktReady) begin
                    trc.overrun <= 1'b1;
                end else begin
                    trc.pktValid     <= 1'b1;
                    trc.pktData      <= hold_data_c;
                    trc.pktTimeStamp <= hold_ts_c;
                    trc.pktHasTs     <= hold_has_ts_c;
                end
            end else if (trc.pktValid && trc.pktReady) begin
                trc.pktValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_p405s_trc_deserializer.sv
// Directed and randomized checks of the trace deserializer against a beat-queue model.
module tb_p405s_trc_deserializer;
    localparam int unsigned GAP_MAX = 15;

    logic CB = 1'b0;
    logic resetN;
    int   tests = 0;
    int   fails = 0;

    p405s_trc_deserializer_if trc();

    p405s_trc_deserializer #(.GAP_MAX(GAP_MAX)) dut (
        .CB     (CB),
        .resetN (resetN),
        .trc    (trc.slave)
    );

    always #5 CB = ~CB;

    // Reference model: beats collected in a queue, packet built arithmetically.
    logic [2:0]  q[$];
    bit          m_busy;
    bit          m_ts;
    int          m_gap;
    bit          e_valid;
    bit          e_has;
    bit          e_ferr;
    bit          e_ovr;
    logic [29:0] e_data;
    logic [8:0]  e_ts;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy  = 1'b0;
        m_ts    = 1'b0;
        m_gap   = 0;
        e_valid = 1'b0;
        e_has   = 1'b0;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        e_data  = '0;
        e_ts    = '0;
    endtask

    task automatic model_edge(input bit v, input bit s, input bit t, input logic [2:0] b, input bit r);
        bit          done;
        logic [29:0] nd;
        logic [8:0]  nt;
        done   = 1'b0;
        nd     = '0;
        nt     = '0;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        if (v) begin
            if (s) begin
                if (m_busy) e_ferr = 1'b1;
                q.delete();
                q.push_back(b);
                m_ts   = t;
                m_busy = 1'b1;
                m_gap  = 0;
            end else if (!m_busy) begin
                e_ferr = 1'b1;
            end else begin
                q.push_back(b);
                m_gap = 0;
                if (q.size() == (m_ts ? 13 : 10)) begin
                    for (int i = 0; i < 10; i++) nd = (nd << 3) | 30'(q[i]);
                    if (m_ts) for (int i = 10; i < 13; i++) nt = (nt << 3) | 9'(q[i]);
                    done   = 1'b1;
                    m_busy = 1'b0;
                    q.delete();
                end
            end
        end else if (m_busy) begin
            m_gap++;
            if (m_gap > int'(GAP_MAX)) begin
                e_ferr = 1'b1;
                m_busy = 1'b0;
                m_gap  = 0;
                q.delete();
            end
        end
        if (done) begin
            if (e_valid && !r) begin
                e_ovr = 1'b1;
            end else begin
                e_valid = 1'b1;
                e_data  = nd;
                e_ts    = nt;
                e_has   = m_ts;
            end
        end else if (e_valid && r) begin
            e_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("pktValid", 32'(trc.pktValid), 32'(e_valid));
        chk("frameErr", 32'(trc.frameErr), 32'(e_ferr));
        chk("overrun",  32'(trc.overrun),  32'(e_ovr));
        chk("busy",     32'(trc.busy),     32'(m_busy));
        if (e_valid) begin
            chk("pktData",      32'(trc.pktData),      32'(e_data));
            chk("pktTimeStamp", 32'(trc.pktTimeStamp), 32'(e_ts));
            chk("pktHasTs",     32'(trc.pktHasTs),     32'(e_has));
        end
    endtask

    task automatic cyc(input bit v, input bit s, input bit t, input logic [2:0] b, input bit r);
        trc.serValid  = v;
        trc.serStart  = s;
        trc.tsEnable  = t;
        trc.serDataIn = b;
        trc.pktReady  = r;
        @(posedge CB);
        model_edge(v, s, t, b, r);
        #1;
        check_outputs();
    endtask

    // rdy: 0 = low, 1 = high, 2 = random, 3 = low except on the final beat.
    function automatic bit rdy_val(input int rdy, input bit last);
        if (rdy == 2) return 1'($urandom_range(0, 1));
        if (rdy == 3) return last;
        return rdy == 1;
    endfunction

    task automatic send_pkt(input logic [29:0] d, input logic [8:0] ts, input bit tsen,
                            input int gaps, input int rdy, input int nbeats);
        int         n;
        logic [2:0] b;
        n = tsen ? 13 : 10;
        if (nbeats >= 0) n = nbeats;
        for (int k = 0; k < n; k++) begin
            if (k < 10) b = 3'((d >> (27 - 3 * k)) & 30'h7);
            else        b = 3'((ts >> (6 - 3 * (k - 10))) & 9'h7);
            cyc(1'b1, k == 0, tsen, b, rdy_val(rdy, k == n - 1));
            if (k != n - 1) begin
                for (int g = 0; g < gaps; g++)
                    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'($urandom), rdy_val(rdy, 1'b0));
            end
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, r);
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_pktValid"},     32'(trc.pktValid),     32'd0);
        chk({tag, "_pktData"},      32'(trc.pktData),      32'd0);
        chk({tag, "_pktTimeStamp"}, 32'(trc.pktTimeStamp), 32'd0);
        chk({tag, "_pktHasTs"},     32'(trc.pktHasTs),     32'd0);
        chk({tag, "_frameErr"},     32'(trc.frameErr),     32'd0);
        chk({tag, "_overrun"},      32'(trc.overrun),      32'd0);
        chk({tag, "_busy"},         32'(trc.busy),         32'd0);
    endtask

    logic [29:0] d;
    logic [8:0]  t9;

    initial begin
        resetN        = 1'b0;
        trc.serValid  = 1'b0;
        trc.serStart  = 1'b0;
        trc.tsEnable  = 1'b0;
        trc.serDataIn = '0;
        trc.pktReady  = 1'b0;
        model_reset();
        repeat (2) @(posedge CB);
        #1;
        check_reset_zero("reset");
        @(negedge CB);
        resetN = 1'b1;

        // Timestamp packet, back-to-back beats, first beat right after reset release.
        d  = 30'h2AAAAAAA;
        t9 = 9'h1A5;
        send_pkt(d, t9, 1'b1, 0, 1, -1);
        chk("ts_pkt_valid", 32'(trc.pktValid),     32'd1);
        chk("ts_pkt_data",  32'(trc.pktData),      32'h2AAAAAAA);
        chk("ts_pkt_ts",    32'(trc.pktTimeStamp), 32'h1A5);
        chk("ts_pkt_has",   32'(trc.pktHasTs),     32'd1);
        idle(1, 1'b1);
        chk("ts_pkt_oneshot", 32'(trc.pktValid), 32'd0);

        // Short packet with 3-cycle gaps.
        d = 30'($urandom);
        send_pkt(d, 9'h0, 1'b0, 3, 1, -1);
        chk("short_data", 32'(trc.pktData),      32'(d));
        chk("short_ts",   32'(trc.pktTimeStamp), 32'd0);
        chk("short_has",  32'(trc.pktHasTs),     32'd0);
        idle(2, 1'b1);

        // Stray beat in IDLE and serStart without serValid.
        cyc(1'b1, 1'b0, 1'b0, 3'd5, 1'b1);
        chk("stray_ferr", 32'(trc.frameErr), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
        chk("start_novalid_busy", 32'(trc.busy), 32'd0);

        // Restart on beat 5: only the second packet is delivered.
        send_pkt(30'($urandom), 9'($urandom), 1'b1, 0, 1, 5);
        d = 30'($urandom);
        send_pkt(d, 9'h0, 1'b0, 0, 1, -1);
        chk("restart_data", 32'(trc.pktData), 32'(d));
        idle(2, 1'b1);

        // Timeout: 16 idle cycles after beat 4.
        send_pkt(30'($urandom), 9'h0, 1'b0, 0, 1, 5);
        idle(int'(GAP_MAX), 1'b1);
        chk("timeout_busy_before", 32'(trc.busy), 32'd1);
        idle(1, 1'b1);
        chk("timeout_ferr",  32'(trc.frameErr), 32'd1);
        chk("timeout_busy",  32'(trc.busy),     32'd0);
        chk("timeout_valid", 32'(trc.pktValid), 32'd0);
        idle(2, 1'b1);

        // Back-pressure: hold, overrun, then no-bubble reload.
        d = 30'($urandom);
        send_pkt(d, 9'($urandom), 1'b1, 1, 0, -1);
        send_pkt(30'($urandom), 9'h0, 1'b0, 0, 0, -1);
        chk("bp_overrun", 32'(trc.overrun), 32'd1);
        chk("bp_held",    32'(trc.pktData), 32'(d));
        d = 30'($urandom);
        send_pkt(d, 9'h0, 1'b0, 2, 3, -1);
        chk("bp_nobubble_valid", 32'(trc.pktValid), 32'd1);
        chk("bp_nobubble_data",  32'(trc.pktData),  32'(d));
        idle(2, 1'b1);

        // Reset mid-packet at beat 7, then a full packet.
        send_pkt(30'($urandom), 9'h0, 1'b0, 0, 1, 7);
        trc.serValid  = 1'b1;
        trc.serStart  = 1'b0;
        trc.serDataIn = 3'd6;
        #3;
        resetN = 1'b0;
        #1;
        model_reset();
        check_reset_zero("midrst");
        @(negedge CB);
        resetN = 1'b1;
        d  = 30'($urandom);
        t9 = 9'($urandom);
        send_pkt(d, t9, 1'b1, 0, 1, -1);
        chk("post_rst_data", 32'(trc.pktData),      32'(d));
        chk("post_rst_ts",   32'(trc.pktTimeStamp), 32'(t9));
        idle(2, 1'b1);

        // Randomized traffic: mixed lengths, gaps, back-pressure, restarts and stray beats.
        for (int p = 0; p < 60; p++) begin
            int nb;
            bit tsen;
            tsen = 1'($urandom_range(0, 1));
            nb   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, tsen ? 12 : 9)) : -1;
            send_pkt(30'($urandom), 9'($urandom), tsen, int'($urandom_range(0, 3)), 2, nb);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                cyc(1'($urandom_range(0, 7) == 0), 1'b0, 1'b0, 3'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
